// File: rtl/write_buffer.sv
// Posted write buffer: queues CPU writes in a FIFO and drains them to memory one at a time,
// always leaving at least one low cycle of mem_wen between consecutive writes.
module write_buffer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 30,
   parameter int unsigned DW    = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cpu_wen,
   input  logic [AW-1:0]          cpu_waddr,
   input  logic [DW-1:0]          cpu_wdata,
   input  logic                   cpu_ren,
   input  logic [AW-1:0]          cpu_raddr,
   output logic                   cpu_stall,
   output logic                   mem_wen,
   output logic [AW-1:0]          mem_addr,
   output logic [DW-1:0]          mem_wdata,
   input  logic                   mem_ready,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] FullCount = (PW+1)'(DEPTH);

   typedef enum logic [1:0] {StIdle, StWrite, StGap} state_e;

   state_e        state_q;
   logic [AW-1:0] addr_mem [DEPTH];
   logic [DW-1:0] data_mem [DEPTH];
   logic [PW-1:0] wptr_q;
   logic [PW-1:0] rptr_q;
   logic          full;
   logic          push;
   logic          pop;
   logic          hazard;

   assign full = (count == FullCount);
   assign push = cpu_wen && !full;
   assign pop  = (state_q == StWrite) && mem_ready;

   // The entry currently on the memory port stays in the FIFO until popped, so it is
   // still covered by the read-hazard scan.
   always_comb begin
      hazard = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (((PW+1)'(i) < count) && (addr_mem[rptr_q + PW'(i)] == cpu_raddr)) begin
            hazard = 1'b1;
         end
      end
   end

   assign cpu_stall = (cpu_wen && full) || (cpu_ren && hazard);

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wptr_q] <= cpu_waddr;
         data_mem[wptr_q] <= cpu_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         count  <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   // GAP only exists to force one low cycle of mem_wen; on its edge it acts like IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         mem_wen   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         case (state_q)
            StWrite: begin
               if (mem_ready) begin
                  mem_wen <= 1'b0;
                  state_q <= StGap;
               end
            end
            default: begin
               if (count != '0) begin
                  mem_wen   <= 1'b1;
                  mem_addr  <= addr_mem[rptr_q];
                  mem_wdata <= data_mem[rptr_q];
                  state_q   <= StWrite;
               end else begin
                  state_q <= StIdle;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_write_buffer.sv
// Bench for write_buffer: queue-based reference model compared every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_write_buffer;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned AW    = 30;
   localparam int unsigned DW    = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cpu_wen = 1'b0;
   logic [AW-1:0] cpu_waddr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic          cpu_ren = 1'b0;
   logic [AW-1:0] cpu_raddr = '0;
   logic          cpu_stall;
   logic          mem_wen;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ready = 1'b0;
   logic [2:0]    count;

   write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_wen   (cpu_wen),
      .cpu_waddr (cpu_waddr),
      .cpu_wdata (cpu_wdata),
      .cpu_ren   (cpu_ren),
      .cpu_raddr (cpu_raddr),
      .cpu_stall (cpu_stall),
      .mem_wen   (mem_wen),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .count     (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   int   checks   = 0;
   int   failures = 0;
   ent_t q[$];
   ent_t accepted[$];
   bit            m_busy = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [DW-1:0] m_data = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit model_stall();
      bit hz = 1'b0;
      if (cpu_ren) begin
         foreach (q[i]) if (q[i].a == cpu_raddr) hz = 1'b1;
      end
      return (cpu_wen && (q.size() == DEPTH)) || hz;
   endfunction

   task automatic model_reset();
      q.delete();
      m_busy = 1'b0;
      m_addr = '0;
      m_data = '0;
   endtask

   // Memory port is either presenting the queue head or released; a release always lasts
   // at least one cycle because a fresh head is only picked up from the released state.
   task automatic model_edge();
      bit   pop;
      bit   push;
      ent_t e;
      if (rst) return;
      pop  = m_busy && mem_ready;
      push = cpu_wen && (q.size() < DEPTH);
      if (!m_busy && (q.size() > 0)) begin
         m_busy = 1'b1;
         m_addr = q[0].a;
         m_data = q[0].d;
      end else if (pop) begin
         m_busy = 1'b0;
      end
      if (pop) void'(q.pop_front());
      if (push) begin
         e.a = cpu_waddr;
         e.d = cpu_wdata;
         q.push_back(e);
      end
   endtask

   task automatic compare_all();
      ent_t e;
      chk("mem_wen", 64'(mem_wen), 64'(m_busy));
      chk("mem_addr", 64'(mem_addr), 64'(m_addr));
      chk("mem_wdata", 64'(mem_wdata), 64'(m_data));
      chk("count", 64'(count), 64'(q.size()));
      chk("cpu_stall", 64'(cpu_stall), 64'(model_stall()));
      if (!rst && mem_wen && mem_ready) begin
         e.a = mem_addr;
         e.d = mem_wdata;
         accepted.push_back(e);
      end
   endtask

   task automatic tick();
      #1;
      compare_all();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle_ticks(input int n);
      cpu_wen = 1'b0;
      cpu_ren = 1'b0;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state, with a write request present that must not stall an empty buffer.
      cpu_wen = 1'b1;
      #1;
      chk("rst_mem_wen", 64'(mem_wen), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_stall", 64'(cpu_stall), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      @(negedge clk);
      tick();
      rst = 1'b0;
      cpu_wen = 1'b0;

      // Single write with mem_ready held high.
      cpu_wen = 1'b1; cpu_waddr = 30'hFF; cpu_wdata = 32'h68010000; mem_ready = 1'b1;
      tick();
      cpu_wen = 1'b0;
      chk("single_count_after_push", 64'(count), 64'd1);
      chk("single_wen_at_n", 64'(mem_wen), 64'd0);
      tick();
      chk("single_wen_at_n1", 64'(mem_wen), 64'd1);
      chk("single_addr", 64'(mem_addr), 64'hFF);
      chk("single_data", 64'(mem_wdata), 64'h68010000);
      tick();
      chk("single_wen_low", 64'(mem_wen), 64'd0);
      chk("single_count_zero", 64'(count), 64'd0);
      idle_ticks(2);

      // Burst of four back-to-back writes.
      accepted.delete();
      for (int i = 0; i < 4; i++) begin
         cpu_wen = 1'b1; cpu_waddr = 30'hFF; cpu_wdata = 32'(i);
         #1;
         chk("burst_no_stall", 64'(cpu_stall), 64'd0);
         tick();
      end
      idle_ticks(10);
      chk("burst_pulses", 64'(accepted.size()), 64'd4);
      for (int i = 0; i < 4 && i < accepted.size(); i++) begin
         chk("burst_order", 64'(accepted[i].d), 64'(i));
      end

      // Full buffer: fifth write stalls until the first pop frees a slot.
      accepted.delete();
      mem_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cpu_wen = 1'b1; cpu_waddr = 30'(32 + i); cpu_wdata = 32'(32'hA0 + i);
         if (i < 4) tick();
      end
      #1;
      chk("full_count", 64'(count), 64'd4);
      chk("full_stall", 64'(cpu_stall), 64'd1);
      tick();
      mem_ready = 1'b1;
      #1;
      chk("full_stall_held", 64'(cpu_stall), 64'd1);
      tick();
      chk("full_count_after_pop", 64'(count), 64'd3);
      #1;
      chk("full_stall_released", 64'(cpu_stall), 64'd0);
      tick();
      chk("full_fifth_accepted", 64'(count), 64'd4);
      idle_ticks(14);
      chk("full_drained", 64'(accepted.size()), 64'd5);
      for (int i = 0; i < 5 && i < accepted.size(); i++) begin
         chk("full_order", 64'(accepted[i].d), 64'(32'hA0 + i));
      end

      // Read hazard against a pending entry.
      mem_ready = 1'b0;
      cpu_wen = 1'b1; cpu_waddr = 30'h10; cpu_wdata = 32'h55;
      tick();
      cpu_wen = 1'b0; cpu_ren = 1'b1; cpu_raddr = 30'h10;
      #1;
      chk("hazard_pending", 64'(cpu_stall), 64'd1);
      tick();
      tick();
      chk("hazard_presented", 64'(mem_wen), 64'd1);
      #1;
      chk("hazard_on_port", 64'(cpu_stall), 64'd1);
      cpu_raddr = 30'h11;
      #1;
      chk("hazard_other_addr", 64'(cpu_stall), 64'd0);
      cpu_raddr = 30'h10; mem_ready = 1'b1;
      #1;
      chk("hazard_before_pop", 64'(cpu_stall), 64'd1);
      tick();
      #1;
      chk("hazard_cleared", 64'(cpu_stall), 64'd0);
      idle_ticks(2);

      // Reset while a write is on the memory port.
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cpu_wen = 1'b1; cpu_waddr = 30'(48 + i); cpu_wdata = 32'(32'hC0 + i);
         tick();
      end
      cpu_wen = 1'b0;
      chk("rst_mid_wen_before", 64'(mem_wen), 64'd1);
      chk("rst_mid_count_before", 64'(count), 64'd3);
      rst = 1'b1;
      #1;
      chk("rst_mid_wen_async", 64'(mem_wen), 64'd0);
      chk("rst_mid_count_async", 64'(count), 64'd0);
      model_reset();
      tick();
      rst = 1'b0;
      mem_ready = 1'b1;
      idle_ticks(6);
      chk("rst_mid_no_resume", 64'(mem_wen), 64'd0);

      // Randomized traffic with occasional asynchronous resets.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 299) == 0) begin
            #2;
            rst = 1'b1;
            #1;
            model_reset();
            tick();
            rst = 1'b0;
         end else begin
            cpu_wen   = ($urandom_range(0, 1) == 1);
            cpu_waddr = 30'($urandom_range(0, 7));
            cpu_wdata = $urandom;
            cpu_ren   = ($urandom_range(0, 9) < 4);
            cpu_raddr = 30'($urandom_range(0, 7));
            mem_ready = ($urandom_range(0, 9) < 6);
            tick();
         end
      end
      mem_ready = 1'b1;
      idle_ticks(16);
      chk("final_empty", 64'(count), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
